uart_block_transmitter: RTL and testbench

UART_BLOCK_TRANSMITTER -- requirements
Module: uart_block_transmitter

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_byte_serializer.sv | 60 ++++++
 rtl/uart_block_transmitter.sv | 63 ++++++
 tb/tb_uart_block_transmitter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and size defaults (no ports)
package uart_pkg;
  localparam int NUM_BYTES_DEF = 48;
  localparam int OVERSAMPLE_DEF = 16;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/uart_byte_serializer.sv
// uart_byte_serializer: 8N1 byte sender; in clk/rst_n/abort/load/din, out tx/bit_end (last cycle of a bit)/bit_idx (0 start, 1-8 data, 9 stop)
module uart_byte_serializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       load,
  input  logic [7:0] din,
  output logic       tx,
  output logic       bit_end,
  output logic [3:0] bit_idx
);
  localparam int CW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  logic [9:0] frame_q, frame_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0] bit_q, bit_d;
  logic active_q, active_d;
  assign bit_end = active_q & (cyc_q == CW'(OVERSAMPLE - 1));
  assign bit_idx = bit_q;
  assign tx = frame_q[0];
  always_comb begin
    frame_d = frame_q;
    cyc_d = cyc_q;
    bit_d = bit_q;
    active_d = active_q;
    if (abort) begin
      frame_d = '1;
      cyc_d = '0;
      bit_d = '0;
      active_d = 1'b0;
    end else if (load) begin
      frame_d = {1'b1, din, 1'b0};
      cyc_d = '0;
      bit_d = '0;
      active_d = 1'b1;
    end else if (bit_end) begin
      frame_d = {1'b1, frame_q[9:1]};
      cyc_d = '0;
      bit_d = bit_q == 4'd9 ? 4'd0 : bit_q + 4'd1;
      active_d = bit_q != 4'd9;
    end else if (active_q) begin
      cyc_d = cyc_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_q <= '1;
      cyc_q <= '0;
      bit_q <= '0;
      active_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      cyc_q <= cyc_d;
      bit_q <= bit_d;
      active_q <= active_d;
    end
endmodule

// File: rtl/uart_block_transmitter.sv
// uart_block_transmitter: sends NUM_BYTES of data as back-to-back 8N1 frames; in clk/rst_n/en/start/data, out tx/busy/done/byte_counter
module uart_block_transmitter
  import uart_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] data,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic [5:0]             byte_counter
);
  logic [2:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
  logic legal, abort, accept, bit_end, byte_end, last_byte, next_byte, load;
  logic [3:0] bit_idx;
  logic [7:0] din;
  assign legal = state_q <= ST_DONE;
  assign abort = ~en | ~legal;
  assign accept = en & start & (state_q == ST_IDLE | state_q == ST_DONE);
  assign byte_end = state_q == ST_STOP & bit_end;
  assign last_byte = cnt_q == 6'(NUM_BYTES - 1);
  assign next_byte = en & byte_end & ~last_byte;
  assign load = accept | next_byte;
  assign din = accept ? data[7:0] : shadow_q[15:8];
  assign busy = state_q == ST_START | state_q == ST_DATA | state_q == ST_STOP;
  assign done = state_q == ST_DONE;
  assign byte_counter = cnt_q;
  always_comb begin
    state_d = abort ? ST_IDLE : accept ? ST_START : ~bit_end ? state_q :
              state_q == ST_START ? ST_DATA :
              state_q == ST_DATA ? (bit_idx == 4'd8 ? ST_STOP : ST_DATA) :
              state_q == ST_STOP ? (last_byte ? ST_DONE : ST_START) : state_q;
    cnt_d = abort | accept ? 6'd0 : byte_end ? cnt_q + 6'd1 : cnt_q;
    shadow_d = accept ? data : next_byte ? shadow_q >> 8 : shadow_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
    end
  uart_byte_serializer #(.OVERSAMPLE(OVERSAMPLE)) u_ser (
    .clk(clk),
    .rst_n(rst_n),
    .abort(abort),
    .load(load),
    .din(din),
    .tx(tx),
    .bit_end(bit_end),
    .bit_idx(bit_idx)
  );
endmodule

// File: tb/tb_uart_block_transmitter.sv
// tb_uart_block_transmitter: self-checking bench comparing the line against an 8N1 frame model and a sampling receiver
module tb_uart_block_transmitter;
  localparam int NB = 48;
  localparam int OS = 16;
  localparam int L = 8 * NB;
  localparam int FRAME = 10 * OS;
  localparam int TOTAL = FRAME * NB;
  logic clk = 1'b0, rst_n, en, start, tx, busy, done;
  logic [L-1:0] data;
  logic [5:0] byte_counter;
  int checks = 0, failures = 0;
  typedef struct {logic en, st, tx, busy, done; logic [5:0] cnt;} vec_t;
  vec_t tbl[6];
  uart_block_transmitter #(.NUM_BYTES(NB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .data(data),
    .tx(tx), .busy(busy), .done(done), .byte_counter(byte_counter)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic chkw(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic exp_bit(input logic [L-1:0] d, input int k);
    int b, p;
    b = k / FRAME;
    p = (k / OS) % 10;
    return p == 0 ? 1'b0 : p == 9 ? 1'b1 : d[8*b+p-1];
  endfunction
  function automatic logic [L-1:0] rand_block();
    logic [L-1:0] d;
    for (int i = 0; i < L / 32; i++) d[32*i+:32] = $urandom;
    return d;
  endfunction
  task automatic run_block(input logic [L-1:0] d, input int repulse_k, input int change_k,
                           input int abort_k, input int rst_k);
    logic [L-1:0] rx;
    int werr, serr, p;
    rx = '0;
    werr = 0;
    serr = 0;
    data = d;
    en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("tx_low_latency", tx, 0);
    for (int k = 0; k < TOTAL; k++) begin
      if (k == abort_k) begin
        en = 1'b0;
        tick();
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", byte_counter, 0);
        chk("abort_done", done, 0);
        en = 1'b1;
        return;
      end
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_done", done, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_cnt", byte_counter, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        serr = 0;
        for (int j = 0; j < 40; j++) begin
          tick();
          if (done !== 1'b0 || tx !== 1'b1) serr++;
        end
        chk("rst_done_never_rises", serr, 0);
        return;
      end
      if (tx !== exp_bit(d, k)) begin
        if (werr == 0) $display("FAIL waveform k=%0d actual=%b required=%b", k, tx, exp_bit(d, k));
        werr++;
      end
      if (busy !== 1'b1 || done !== 1'b0 || byte_counter !== 6'(k / FRAME)) serr++;
      p = (k / OS) % 10;
      if (k % OS == OS / 2 && p >= 1 && p <= 8) rx[8*(k/FRAME)+p-1] = tx;
      start = k == repulse_k;
      if (k == change_k) data = ~d;
      tick();
    end
    chk("waveform_errors", werr, 0);
    chk("busy_done_cnt_errors", serr, 0);
    chkw("rx_reassembled", rx, d);
    chk("done_at_end", done, 1);
    chk("busy_at_end", busy, 0);
    chk("cnt_at_end", byte_counter, NB);
    chk("tx_at_end", tx, 1);
    repeat (5) tick();
    chk("done_held", done, 1);
    chk("tx_held", tx, 1);
  endtask
  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
    rst_n = 1'b1;
    en = 1'b0;
    start = 1'b0;
    data = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt", byte_counter, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    data = rand_block();
    for (int i = 0; i < 6; i++) begin
      en = tbl[i].en;
      start = tbl[i].st;
      tick();
      chk($sformatf("vec%0d_tx", i), tx, tbl[i].tx);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_done", i), done, tbl[i].done);
      chk($sformatf("vec%0d_cnt", i), byte_counter, tbl[i].cnt);
    end
    start = 1'b0;
    run_block(L'(1), -1, -1, -1, -1);
    run_block({NB{8'hA5}}, -1, -1, -1, -1);
    run_block(rand_block(), -1, -1, -1, -1);
    run_block(rand_block(), -1, -1, 10 * FRAME + 3 * OS + 5, -1);
    run_block(rand_block(), -1, -1, -1, -1);
    run_block(rand_block(), 500, 300, -1, -1);
    run_block(rand_block(), -1, -1, -1, 47 * FRAME + 9 * OS + 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
